// File: rtl/motor_pkg.sv
// Shared types and encodings for the motor travel controller.
// Includes the FSM state enum, the dir_req command codes and the fault_code values.
package motor_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN_UP = 3'd1,
    ST_RUN_DN = 3'd2,
    ST_DEAD   = 3'd3,
    ST_FAULT  = 3'd4
  } state_t;

  localparam logic [1:0] DIR_TOGGLE = 2'b00;
  localparam logic [1:0] DIR_UP     = 2'b01;
  localparam logic [1:0] DIR_DN     = 2'b10;

  localparam logic [1:0] FC_NONE   = 2'b00;
  localparam logic [1:0] FC_TMO    = 2'b01;
  localparam logic [1:0] FC_LIMITS = 2'b10;

  function automatic logic is_active(input state_t s);
    return (s == ST_RUN_UP) || (s == ST_RUN_DN) || (s == ST_DEAD);
  endfunction

endpackage

// File: rtl/motor_cnt.sv
// Loadable saturating up-counter with a terminal-count flag.
// The controller shares one instance between run timeout and dead time.
module motor_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic [W-1:0] term,
  output logic         tc
);

  logic [W-1:0] count;

  // Saturates at all-ones so a stuck enable can never wrap back below term.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count >= term);

endmodule

// File: rtl/motor_travel_ctrl.sv
// Up/down travel controller with end-stop sensing, run timeout and post-move dead time.
// All outputs are registered from the next state, so they line up with the state register.
module motor_travel_ctrl
  import motor_pkg::*;
#(
  parameter int TMO_CYC  = 1000,
  parameter int DEAD_CYC = 4,
  parameter int CNT_W    = $clog2(TMO_CYC + 1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       activate,
  input  logic [1:0] dir_req,
  input  logic       up_limit,
  input  logic       dn_limit,
  input  logic       abort,
  input  logic       fault_clr,
  output logic       motor_up,
  output logic       motor_dn,
  output logic       busy,
  output logic       done,
  output logic       fault,
  output logic [1:0] fault_code
);

  // Widened so the dead-time terminal value always fits even for tiny timeouts.
  localparam int CW = (CNT_W > 8) ? CNT_W : 8;
  localparam logic [CW-1:0] TMO_TERM  = CW'(TMO_CYC - 1);
  localparam logic [CW-1:0] DEAD_TERM = CW'(DEAD_CYC - 1);

  state_t      state, next_state;
  logic [1:0]  cause;
  logic        done_set;
  logic        target;
  logic        cnt_load, cnt_en, cnt_tc;
  logic [CW-1:0] cnt_term;
  logic        motor_up_nx, motor_dn_nx, busy_nx, done_nx, fault_nx;
  logic [1:0]  fault_code_nx;

  assign cnt_term = (state == ST_DEAD) ? DEAD_TERM : TMO_TERM;
  assign cnt_en   = is_active(state);
  assign cnt_load = is_active(next_state) && (next_state != state);

  motor_cnt #(.W(CW)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val ('0),
    .en       (cnt_en),
    .term     (cnt_term),
    .tc       (cnt_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      motor_up   <= 1'b0;
      motor_dn   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      fault      <= 1'b0;
      fault_code <= FC_NONE;
    end else begin
      state      <= next_state;
      motor_up   <= motor_up_nx;
      motor_dn   <= motor_dn_nx;
      busy       <= busy_nx;
      done       <= done_nx;
      fault      <= fault_nx;
      fault_code <= fault_code_nx;
    end
  end

  // Run priority: both limits, then target limit, then abort, then timeout.
  always_comb begin
    next_state = state;
    cause      = FC_NONE;
    done_set   = 1'b0;
    target     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (activate && (dir_req != 2'b11)) begin
          if (up_limit && dn_limit) begin
            next_state = ST_FAULT;
            cause      = FC_LIMITS;
          end else begin
            case (dir_req)
              DIR_TOGGLE: next_state = up_limit ? ST_RUN_DN : ST_RUN_UP;
              DIR_UP: begin
                if (up_limit) done_set = 1'b1;
                else          next_state = ST_RUN_UP;
              end
              DIR_DN: begin
                if (dn_limit) done_set = 1'b1;
                else          next_state = ST_RUN_DN;
              end
              default: next_state = state;
            endcase
          end
        end
      end
      ST_RUN_UP, ST_RUN_DN: begin
        target = (state == ST_RUN_UP) ? up_limit : dn_limit;
        if (up_limit && dn_limit) begin
          next_state = ST_FAULT;
          cause      = FC_LIMITS;
        end else if (target) begin
          next_state = ST_DEAD;
          done_set   = 1'b1;
        end else if (abort) begin
          next_state = ST_DEAD;
        end else if (cnt_tc) begin
          next_state = ST_FAULT;
          cause      = FC_TMO;
        end
      end
      ST_DEAD: begin
        if (cnt_tc) next_state = ST_IDLE;
      end
      ST_FAULT: begin
        if (fault_clr) next_state = ST_IDLE;
      end
      default: begin
        next_state = ST_FAULT;
        cause      = FC_TMO;
      end
    endcase
  end

  always_comb begin
    motor_up_nx   = (next_state == ST_RUN_UP);
    motor_dn_nx   = (next_state == ST_RUN_DN);
    busy_nx       = is_active(next_state);
    done_nx       = done_set;
    fault_nx      = (next_state == ST_FAULT);
    fault_code_nx = FC_NONE;
    if (next_state == ST_FAULT) begin
      fault_code_nx = (state == ST_FAULT) ? fault_code : cause;
    end
  end

endmodule

// File: doc/motor_travel_ctrl.md
MOTOR_TRAVEL_CTRL -- requirements
Module: motor_travel_ctrl

Interface
REQ-001 Parameter TMO_CYC, default 1000, max cycles a move may run before timeout fault; legal range 2..2^20.
REQ-002 Parameter DEAD_CYC, default 4, motor-off cycles after every move before a new command is accepted; legal range 1..255.
REQ-003 Parameter CNT_W, default $clog2(TMO_CYC+1), width of the shared run/dead-time counter.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 activate  in  1  move request, level-sampled in IDLE only.
REQ-007 dir_req  in  2  00 toggle, 01 up, 10 down, 11 reserved (treated as no request).
REQ-008 up_limit, dn_limit  in  1 each  end-stop sensors, high at limit.
REQ-009 abort  in  1  stop the current move.
REQ-010 fault_clr  in  1  leave FAULT.
REQ-011 motor_up, motor_dn  out  1 each  registered motor drives.
REQ-012 busy  out  1  high in every state except IDLE and FAULT.
REQ-013 done  out  1  one-cycle pulse on completing a move at the target limit.
REQ-014 fault  out  1  high in FAULT.
REQ-015 fault_code  out  2  00 none, 01 timeout, 10 both limits active; held until fault_clr.

Function
REQ-016 States: IDLE, RUN_UP, RUN_DN, DEAD, FAULT; all outputs registered.
REQ-017 IDLE with activate=1 and up_limit=dn_limit=1 -> FAULT, fault_code=10.
REQ-018 IDLE with activate=1, toggle: up_limit=1 -> RUN_DN, otherwise -> RUN_UP.
REQ-019 IDLE with activate=1, dir_req=01: up_limit=1 -> stay IDLE, pulse done next cycle, no motor drive; otherwise -> RUN_UP. dir_req=10 is symmetric with dn_limit and RUN_DN.
REQ-020 dir_req=11 in IDLE: no transition.
REQ-021 motor_up=1 in exactly the cycles the FSM is in RUN_UP; motor_dn likewise for RUN_DN; both never high together.
REQ-022 Counter clears on entry to RUN_* and increments each RUN_* cycle; the target limit is sampled every RUN_* cycle, including the first.
REQ-023 RUN_UP with up_limit=1 (RUN_DN with dn_limit=1) -> DEAD; done pulses in the first DEAD cycle.
REQ-024 RUN_* with abort=1 and target limit low -> DEAD, no done pulse; limit has priority over abort, and abort over timeout.
REQ-025 RUN_* when the counter reaches TMO_CYC-1 with target limit low -> FAULT, fault_code=01; motors low from the next cycle.
REQ-026 RUN_* with both limits high -> FAULT, fault_code=10, overriding REQ-023..025.
REQ-027 DEAD holds for exactly DEAD_CYC cycles, motors low, then -> IDLE; activate during DEAD is ignored and not queued.
REQ-028 FAULT: motors low; fault_clr=1 -> IDLE, fault and fault_code cleared next cycle; activate is ignored.
REQ-029 Counter saturates and never wraps; unused states decode to FAULT with fault_code=01.

Reset
REQ-030 rst=1 at a clock edge forces IDLE, counter=0 and all outputs low, overriding every input.
REQ-031 Reset during RUN_* drops motor drives at that edge with no dead time, no done and no fault.

Structure
REQ-032 Shared package motor_pkg holds the state enum, the dir_req encodings (DIR_TOGGLE, DIR_UP, DIR_DN) and the fault_code encodings (FC_NONE, FC_TMO, FC_LIMITS).
REQ-033 One sub-module, motor_cnt: a loadable saturating counter with a terminal-count flag, used for both run timeout and dead time.

Verification (TMO_CYC=16, DEAD_CYC=2)
REQ-034 Toggle with both limits low, activate=1, up_limit high after 5 RUN_UP cycles -> motor_up high 5 cycles, 2 DEAD cycles, done one pulse, busy high 7 cycles.
REQ-035 Toggle with up_limit=1, activate=1 -> RUN_DN; dn_limit at cycle 3 -> motor_dn high 3 cycles, done pulse.
REQ-036 dir_req=01, limits low, no up_limit -> motor_up high 16 cycles, then fault=1 and fault_code=01; fault_clr -> IDLE, fault=0.
REQ-037 RUN_UP cycle 4 with abort=1 and up_limit=1 in the same cycle -> limit wins, done pulses; repeat with abort alone -> DEAD, no done.
REQ-038 dir_req=10 with dn_limit=1 -> no motor drive, done pulse; activate with both limits high -> fault_code=10.
REQ-039 rst=1 in RUN_DN cycle 3 -> motor_dn low and busy low next cycle; assertion that motor_up and motor_dn are never both high holds throughout.
